// File: rtl/tlb_op_ctrl_pkg.sv
// tlb_op_ctrl_pkg: shared definitions for the TLB management-op sequencer.
//   TLBOP_*       : EX op_code encodings for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
//   INVTLB_OP_MAX : largest legal INVTLB op field; larger values raise INE
//   state_e       : sequencer states
package tlb_op_ctrl_pkg;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SRCH_ARB,
    ST_SRCH_WAIT,
    ST_RD_CAP,
    ST_WRITE,
    ST_INV,
    ST_DONE
  } state_e;

  function automatic logic inv_type_ok(input logic [4:0] inv_type);
    return inv_type <= INVTLB_OP_MAX;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_rand_ctr.sv
// tlb_rand_ctr: free-running index counter for TLBFILL.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   freeze     : hold the current value this cycle
//   value      : current count, always in 0..TLBNUM-1
module tlb_rand_ctr #(
  parameter  int unsigned TLBNUM = 8,
  localparam int unsigned IDXW   = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            freeze,
  output logic [IDXW-1:0] value
);

  logic [IDXW-1:0] cnt_q, cnt_d;

  // Explicit wrap at TLBNUM-1 so non-power-of-2 sizes never emit an out-of-range index.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      cnt_d = (cnt_q == IDXW'(TLBNUM - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value = cnt_q;

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLB management ops from EX onto the TLB ports.
//   op_valid/op_ready/op_* : op handshake and operands from EX
//   data_port_busy/data_hold, srch_req/srch_found/srch_index : search port 1 sharing
//   tlbwr_en/tlbfill_en/rand_index : TLB write strobes and fill index
//   invtlb_* : invalidate strobe with registered operands
//   csr_tlbidx_*/csr_tlbrd_we : CSR write-back strobes
//   done/ine/refetch : completion pulse to the pipeline
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter  int unsigned TLBNUM     = 8,
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned IDXW       = (TLBNUM > 1) ? $clog2(TLBNUM) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [4:0]      op_inv_type,
  input  logic [9:0]      op_inv_asid,
  input  logic [18:0]     op_inv_vpn,
  input  logic            data_port_busy,
  output logic            data_hold,
  output logic            srch_req,
  input  logic            srch_found,
  input  logic [IDXW-1:0] srch_index,
  output logic            tlbwr_en,
  output logic            tlbfill_en,
  output logic [IDXW-1:0] rand_index,
  output logic            invtlb_en,
  output logic [4:0]      invtlb_op,
  output logic [9:0]      invtlb_asid,
  output logic [18:0]     invtlb_vpn,
  output logic            csr_tlbidx_we,
  output logic            csr_tlbidx_ne,
  output logic [IDXW-1:0] csr_tlbidx_idx,
  output logic            csr_tlbrd_we,
  output logic            done,
  output logic            ine,
  output logic            refetch
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_e         state_q, state_d;
  logic [2:0]     code_q, code_d;
  logic [4:0]     inv_type_q, inv_type_d;
  logic [9:0]     inv_asid_q, inv_asid_d;
  logic [18:0]    inv_vpn_q, inv_vpn_d;
  logic [SW-1:0]  starve_q, starve_d;

  tlb_rand_ctr #(.TLBNUM(TLBNUM)) u_rand_ctr (
    .clk    (clk),
    .reset  (reset),
    .freeze (state_q == ST_WRITE),
    .value  (rand_index)
  );

  assign invtlb_op   = inv_type_q;
  assign invtlb_asid = inv_asid_q;
  assign invtlb_vpn  = inv_vpn_q;

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    inv_type_d     = inv_type_q;
    inv_asid_d     = inv_asid_q;
    inv_vpn_d      = inv_vpn_q;
    starve_d       = starve_q;
    op_ready       = (state_q == ST_IDLE);
    data_hold      = 1'b0;
    srch_req       = 1'b0;
    tlbwr_en       = 1'b0;
    tlbfill_en     = 1'b0;
    invtlb_en      = 1'b0;
    csr_tlbidx_we  = 1'b0;
    csr_tlbidx_ne  = 1'b0;
    csr_tlbidx_idx = '0;
    csr_tlbrd_we   = 1'b0;
    done           = 1'b0;
    ine            = 1'b0;
    refetch        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          code_d     = op_code;
          inv_type_d = op_inv_type;
          inv_asid_d = op_inv_asid;
          inv_vpn_d  = op_inv_vpn;
          case (op_code)
            TLBOP_SRCH: state_d = ST_SRCH_ARB;
            TLBOP_RD:   state_d = ST_RD_CAP;
            TLBOP_WR,
            TLBOP_FILL: state_d = ST_WRITE;
            TLBOP_INV:  state_d = inv_type_ok(op_inv_type) ? ST_INV : ST_DONE;
            // Undefined opcodes retire as a plain done with no side effects.
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_SRCH_ARB: begin
        // Data lookups win until the pending search has waited STARVE_MAX-1 cycles.
        if (!data_port_busy || (starve_q == SW'(STARVE_MAX - 1))) begin
          srch_req  = 1'b1;
          data_hold = 1'b1;
          state_d   = ST_SRCH_WAIT;
        end else begin
          starve_d = starve_q + 1'b1;
        end
      end
      ST_SRCH_WAIT: begin
        csr_tlbidx_we  = 1'b1;
        csr_tlbidx_ne  = !srch_found;
        csr_tlbidx_idx = srch_index;
        starve_d       = '0;
        state_d        = ST_DONE;
      end
      ST_RD_CAP: begin
        csr_tlbrd_we = 1'b1;
        state_d      = ST_DONE;
      end
      ST_WRITE: begin
        if (code_q == TLBOP_FILL) tlbfill_en = 1'b1;
        else                      tlbwr_en   = 1'b1;
        state_d = ST_DONE;
      end
      ST_INV: begin
        invtlb_en = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        ine     = (code_q == TLBOP_INV) && !inv_type_ok(inv_type_q);
        refetch = (code_q == TLBOP_WR) || (code_q == TLBOP_FILL) ||
                  ((code_q == TLBOP_INV) && inv_type_ok(inv_type_q));
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // No strobe may escape during the reset cycle of an aborted operation.
    if (reset) begin
      data_hold      = 1'b0;
      srch_req       = 1'b0;
      tlbwr_en       = 1'b0;
      tlbfill_en     = 1'b0;
      invtlb_en      = 1'b0;
      csr_tlbidx_we  = 1'b0;
      csr_tlbidx_ne  = 1'b0;
      csr_tlbidx_idx = '0;
      csr_tlbrd_we   = 1'b0;
      done           = 1'b0;
      ine            = 1'b0;
      refetch        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      inv_type_q <= '0;
      inv_asid_q <= '0;
      inv_vpn_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      inv_type_q <= inv_type_d;
      inv_asid_q <= inv_asid_d;
      inv_vpn_q  <= inv_vpn_d;
      starve_q   <= starve_d;
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: scoreboard bench for tlb_op_ctrl.
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int unsigned TLBNUM     = 8;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned IDXW       = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [2:0]      op_code = '0;
  logic [4:0]      op_inv_type = '0;
  logic [9:0]      op_inv_asid = '0;
  logic [18:0]     op_inv_vpn = '0;
  logic            data_port_busy = 1'b0;
  logic            data_hold, srch_req;
  logic            srch_found = 1'b0;
  logic [IDXW-1:0] srch_index = '0;
  logic            tlbwr_en, tlbfill_en, invtlb_en;
  logic [IDXW-1:0] rand_index;
  logic [4:0]      invtlb_op;
  logic [9:0]      invtlb_asid;
  logic [18:0]     invtlb_vpn;
  logic            csr_tlbidx_we, csr_tlbidx_ne, csr_tlbrd_we;
  logic [IDXW-1:0] csr_tlbidx_idx;
  logic            done, ine, refetch;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_inv_type(op_inv_type), .op_inv_asid(op_inv_asid),
    .op_inv_vpn(op_inv_vpn), .data_port_busy(data_port_busy), .data_hold(data_hold),
    .srch_req(srch_req), .srch_found(srch_found), .srch_index(srch_index),
    .tlbwr_en(tlbwr_en), .tlbfill_en(tlbfill_en), .rand_index(rand_index),
    .invtlb_en(invtlb_en), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
    .invtlb_vpn(invtlb_vpn), .csr_tlbidx_we(csr_tlbidx_we), .csr_tlbidx_ne(csr_tlbidx_ne),
    .csr_tlbidx_idx(csr_tlbidx_idx), .csr_tlbrd_we(csr_tlbrd_we), .done(done),
    .ine(ine), .refetch(refetch)
  );

  typedef struct packed {
    logic            srch_req;
    logic            data_hold;
    logic            wr;
    logic            fill;
    logic            inv;
    logic            idx_we;
    logic            ne;
    logic [IDXW-1:0] idx;
    logic            rd_we;
    logic            done;
    logic            ine;
    logic            refetch;
    logic [4:0]      iop;
    logic [9:0]      iasid;
    logic [18:0]     ivpn;
    logic [IDXW-1:0] rnd;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rc = 0;
  int   freeze_cyc = -1;
  int   busy_lo = 0;
  int   busy_hi = -1;
  bit   mon_en = 1'b0;
  bit   req_seen = 1'b0;
  bit   plan_found = 1'b0;
  logic [IDXW-1:0] plan_idx = '0;

  // Reference time base and fill-index model: one step per cycle, held in the write cycle.
  always @(posedge clk) begin
    if (reset)                 rc = 0;
    else if (cyc != freeze_cyc) rc = (rc + 1) % int'(TLBNUM);
    cyc = cyc + 1;
  end

  // Search-port responder: result valid only in the cycle after a request.
  always @(negedge clk) req_seen = srch_req;
  always @(posedge clk) begin
    #1;
    if (req_seen) begin
      srch_found = plan_found;
      srch_index = plan_idx;
    end else begin
      srch_found = 1'($urandom_range(0, 1));
      srch_index = IDXW'($urandom_range(0, TLBNUM - 1));
    end
  end

  // Monitor: pops scheduled responses and compares whatever the DUT presents.
  always @(negedge clk) begin
    obs_t a;
    exp_t e;
    bit   any;
    if (mon_en) begin
      any = srch_req | data_hold | tlbwr_en | tlbfill_en | invtlb_en | csr_tlbidx_we |
            csr_tlbrd_we | done | ine | refetch;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        errs++; checks++;
        $display("FAIL missed_event cyc=%0d got=none expected=%h", q[0].cyc, q[0].o);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        a = '0;
        a.srch_req  = srch_req;
        a.data_hold = data_hold;
        a.wr        = tlbwr_en;
        a.fill      = tlbfill_en;
        a.inv       = invtlb_en;
        a.idx_we    = csr_tlbidx_we;
        a.rd_we     = csr_tlbrd_we;
        a.done      = done;
        a.ine       = ine;
        a.refetch   = refetch;
        if (e.o.idx_we) begin
          a.ne = csr_tlbidx_ne;
          if (!e.o.ne) a.idx = csr_tlbidx_idx;
        end
        if (e.o.inv) begin
          a.iop   = invtlb_op;
          a.iasid = invtlb_asid;
          a.ivpn  = invtlb_vpn;
        end
        if (e.o.fill) a.rnd = rand_index;
        checks++;
        if (a !== e.o) begin
          errs++;
          $display("FAIL strobes cyc=%0d got=%h expected=%h", cyc, a, e.o);
        end
      end else if (any) begin
        errs++; checks++;
        $display("FAIL unexpected_strobe cyc=%0d got=%b expected=0", cyc,
                 {srch_req, data_hold, tlbwr_en, tlbfill_en, invtlb_en, csr_tlbidx_we,
                  csr_tlbrd_we, done, ine, refetch});
      end
      if (!reset) begin
        checks++;
        if (op_ready !== (cyc < busy_lo || cyc > busy_hi)) begin
          errs++;
          $display("FAIL op_ready cyc=%0d got=%b expected=%b", cyc, op_ready,
                   (cyc < busy_lo || cyc > busy_hi));
        end
      end
      checks++;
      if (rand_index !== IDXW'(rc)) begin
        errs++;
        $display("FAIL rand_index cyc=%0d got=%0d expected=%0d", cyc, rand_index, rc);
      end
    end
  end

  task automatic push(input int c, input obs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    q.push_back(e);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    op_valid       = 1'b0;
    data_port_busy = 1'($urandom_range(0, 1));
  endtask

  // Issues one op in the current cycle, schedules its responses, and runs it to completion.
  task automatic do_op(input logic [2:0] code, input logic [4:0] ityp, input logic [9:0] asid,
                       input logic [18:0] vpn, input bit found, input logic [IDXW-1:0] sidx,
                       input logic [3:0] bpat);
    int   t, last, g;
    obs_t o;
    t = cyc;
    op_valid    = 1'b1;
    op_code     = code;
    op_inv_type = ityp;
    op_inv_asid = asid;
    op_inv_vpn  = vpn;
    plan_found  = found;
    plan_idx    = sidx;
    last        = t;
    case (code)
      TLBOP_RD: begin
        o = '0; o.rd_we = 1'b1; push(t + 1, o);
        o = '0; o.done = 1'b1;  push(t + 2, o);
        last = t + 2;
      end
      TLBOP_WR, TLBOP_FILL: begin
        o = '0;
        if (code == TLBOP_FILL) begin
          o.fill = 1'b1;
          o.rnd  = IDXW'((rc + 1) % int'(TLBNUM));
        end else begin
          o.wr = 1'b1;
        end
        push(t + 1, o);
        o = '0; o.done = 1'b1; o.refetch = 1'b1; push(t + 2, o);
        freeze_cyc = t + 1;
        last = t + 2;
      end
      TLBOP_INV: begin
        if (ityp <= 5'd6) begin
          o = '0; o.inv = 1'b1; o.iop = ityp; o.iasid = asid; o.ivpn = vpn; push(t + 1, o);
          o = '0; o.done = 1'b1; o.refetch = 1'b1; push(t + 2, o);
          last = t + 2;
        end else begin
          o = '0; o.done = 1'b1; o.ine = 1'b1; push(t + 1, o);
          last = t + 1;
        end
      end
      default: begin
        // Search: granted on the first idle data cycle, or forced after STARVE_MAX-1 busy ones.
        g = 0;
        while (g < int'(STARVE_MAX) - 1 && bpat[g]) g++;
        o = '0; o.srch_req = 1'b1; o.data_hold = 1'b1; push(t + 1 + g, o);
        o = '0; o.idx_we = 1'b1; o.ne = !found; if (found) o.idx = sidx; push(t + 2 + g, o);
        o = '0; o.done = 1'b1; push(t + 3 + g, o);
        last = t + 3 + g;
      end
    endcase
    busy_lo = t + 1;
    busy_hi = last;
    for (int c = t + 1; c <= last; c++) begin
      @(posedge clk); #1;
      // Junk offered while busy must be ignored.
      op_valid    = 1'($urandom_range(0, 1));
      op_code     = 3'($urandom_range(0, 7));
      op_inv_type = 5'($urandom_range(0, 31));
      op_inv_asid = 10'($urandom);
      op_inv_vpn  = 19'($urandom);
      data_port_busy = (c - t - 1 < 4) ? bpat[c - t - 1] : 1'($urandom_range(0, 1));
    end
    idle_cycle();
  endtask

  // Offers an op, then asserts reset k cycles into it.
  task automatic abort_op(input logic [2:0] code, input int k);
    int t;
    t = cyc;
    op_valid    = 1'b1;
    op_code     = code;
    op_inv_type = '0;
    busy_lo     = t + 1;
    busy_hi     = t + k;
    for (int c = t + 1; c <= t + k; c++) begin
      @(posedge clk); #1;
      op_valid       = 1'b0;
      data_port_busy = 1'b1;
      if (c == t + k) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset          = 1'b0;
    data_port_busy = 1'b0;
  endtask

  initial begin
    logic [2:0] codes [5];
    logic [2:0] cd;
    codes[0] = TLBOP_SRCH; codes[1] = TLBOP_RD; codes[2] = TLBOP_WR;
    codes[3] = TLBOP_FILL; codes[4] = TLBOP_INV;

    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    idle_cycle();

    do_op(TLBOP_RD,   5'd0, 10'h0,  19'h0,     1'b0, 3'd0, 4'b0000);
    do_op(TLBOP_SRCH, 5'd0, 10'h0,  19'h0,     1'b1, 3'd5, 4'b0000);
    do_op(TLBOP_SRCH, 5'd0, 10'h0,  19'h0,     1'b0, 3'd2, 4'b1111);
    repeat (5) idle_cycle();
    do_op(TLBOP_FILL, 5'd0, 10'h0,  19'h0,     1'b0, 3'd0, 4'b0000);
    do_op(TLBOP_INV,  5'd7, 10'h33, 19'h1234,  1'b0, 3'd0, 4'b0000);
    do_op(TLBOP_INV,  5'd5, 10'h12, 19'h5abcd, 1'b0, 3'd0, 4'b0000);
    do_op(TLBOP_WR,   5'd0, 10'h0,  19'h0,     1'b0, 3'd0, 4'b0000);
    abort_op(TLBOP_WR, 1);
    idle_cycle();
    abort_op(TLBOP_SRCH, 2);
    do_op(TLBOP_SRCH, 5'd0, 10'h0,  19'h0,     1'b1, 3'd6, 4'b1111);
    do_op(TLBOP_SRCH, 5'd0, 10'h0,  19'h0,     1'b1, 3'd7, 4'b0011);
    do_op(TLBOP_INV,  5'd6, 10'h3ff, 19'h7ffff, 1'b0, 3'd0, 4'b0000);

    repeat (80) begin
      cd = codes[$urandom_range(0, 4)];
      do_op(cd, 5'($urandom_range(0, 9)), 10'($urandom), 19'($urandom),
            1'($urandom_range(0, 1)), IDXW'($urandom_range(0, TLBNUM - 1)),
            4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    repeat (4) idle_cycle();
    @(negedge clk);
    while (q.size() > 0) begin
      errs++; checks++;
      $display("FAIL missed_event cyc=%0d got=none expected=%h", q[0].cyc, q[0].o);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
